// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU mode encodings and panel conditioning defaults
package cpu_pkg;

  // CPU mode as seen by cpu, ram and light_show
  typedef enum logic [1:0] {
    CPU_IDLE  = 2'b00,
    CPU_LOAD  = 2'b01,
    CPU_CHECK = 2'b10,
    CPU_RUN   = 2'b11
  } cpustate_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int REPEAT_CYCLES_DEF   = 8;
  localparam int CNT_W_DEF           = 24;

  // Mode target from the two debounced mode switches: {sw1, sw2}
  function automatic cpustate_e mode_decode(input logic sw1, input logic sw2);
    return cpustate_e'({sw1, sw2});
  endfunction

endpackage

// File: rtl/panel_input_if.sv
// rtl/panel_input_if.sv - raw front-panel inputs and conditioned outputs
interface panel_input_if;
  import cpu_pkg::*;

  logic       a1_raw;
  logic       sw1_raw;
  logic       sw2_raw;
  logic       sw_choose_raw;
  logic [7:0] d_raw;

  logic       a1_level;
  logic       a1_pulse;
  logic       sw1;
  logic       sw2;
  logic       sw_choose;
  logic [7:0] d;
  cpustate_e  cpustate;
  logic       state_chg;

  // Board side: drives the raw switches, consumes the conditioned outputs
  modport master (
    output a1_raw, sw1_raw, sw2_raw, sw_choose_raw, d_raw,
    input  a1_level, a1_pulse, sw1, sw2, sw_choose, d, cpustate, state_chg
  );

  // Conditioning stage side
  modport slave (
    input  a1_raw, sw1_raw, sw2_raw, sw_choose_raw, d_raw,
    output a1_level, a1_pulse, sw1, sw2, sw_choose, d, cpustate, state_chg
  );

endinterface

// File: rtl/panel_input_debounce.sv
// rtl/panel_input_debounce.sv - 2-flop synchroniser plus vector debouncer
module debounce
  import cpu_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new value only after it has differed from
  // stable for DEBOUNCE_CYCLES consecutive cycles without itself changing.
  // sync1 != sync2 means sync2 is about to change, so the count restarts
  // together with the new synchronised value and the vector updates atomically.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != stable && cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (sync2 == stable || sync1 != sync2) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign dout = stable;

endmodule

// File: rtl/panel_input.sv
// rtl/panel_input.sv - front-panel conditioning and CPU mode register (option: PANEL_AUTOREPEAT_EN)
module panel_input
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  panel_input_if.slave pif
);

  // Reject configurations the counters cannot represent
  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 || CNT_W < 1 || CNT_W > 31 ||
      ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0 || ((REPEAT_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
    $error("panel_input: illegal DEBOUNCE_CYCLES / REPEAT_CYCLES / CNT_W");
  end

  logic       a1_level;
  logic       sw1;
  logic       sw2;
  logic       sw_choose;
  logic [7:0] d;

  logic       a1_prev;
  logic       a1_pulse_q;
  cpustate_e  cpustate_q;
  logic       state_chg_q;
  cpustate_e  target;
  logic       repeat_hit;

  debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_a1 (
    .clk(clk), .rst(rst), .din(pif.a1_raw), .dout(a1_level)
  );

  debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sw1 (
    .clk(clk), .rst(rst), .din(pif.sw1_raw), .dout(sw1)
  );

  debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sw2 (
    .clk(clk), .rst(rst), .din(pif.sw2_raw), .dout(sw2)
  );

  debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_choose (
    .clk(clk), .rst(rst), .din(pif.sw_choose_raw), .dout(sw_choose)
  );

  debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_d (
    .clk(clk), .rst(rst), .din(pif.d_raw), .dout(d)
  );

  assign target = mode_decode(sw1, sw2);

`ifdef PANEL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt;

  // Repeat counter starts on the cycle after the press pulse and clears when the key drops
  always_ff @(posedge clk) begin
    if (rst || !a1_level || !a1_prev) begin
      rep_cnt <= '0;
    end else if (rep_cnt == REP_LAST) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + CNT_W'(1);
    end
  end

  assign repeat_hit = a1_level & a1_prev & (rep_cnt == REP_LAST);
`else
  assign repeat_hit = 1'b0;
`endif

  // Key edge strobe and mode register; the mode is frozen while the key is held
  always_ff @(posedge clk) begin
    if (rst) begin
      a1_prev     <= 1'b0;
      a1_pulse_q  <= 1'b0;
      cpustate_q  <= CPU_IDLE;
      state_chg_q <= 1'b0;
    end else begin
      a1_prev    <= a1_level;
      a1_pulse_q <= (a1_level & ~a1_prev) | repeat_hit;
      if (!a1_level && target != cpustate_q) begin
        cpustate_q  <= target;
        state_chg_q <= 1'b1;
      end else begin
        state_chg_q <= 1'b0;
      end
    end
  end

  assign pif.a1_level  = a1_level;
  assign pif.a1_pulse  = a1_pulse_q;
  assign pif.sw1       = sw1;
  assign pif.sw2       = sw2;
  assign pif.sw_choose = sw_choose;
  assign pif.d         = d;
  assign pif.cpustate  = cpustate_q;
  assign pif.state_chg = state_chg_q;

endmodule

// File: tb/tb_panel_input.sv
// tb/tb_panel_input.sv - scoreboard bench for panel_input (option: PANEL_AUTOREPEAT_EN)
module tb_panel_input;
  import cpu_pkg::*;

  localparam int DEB = 4;
  localparam int REP = 8;

  typedef struct {
    int         at;
    logic [1:0] st;
  } chg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulse_q[$];
  chg_t chg_q[$];

  panel_input_if pif ();

  panel_input #(.DEBOUNCE_CYCLES(DEB), .CNT_W(24), .REPEAT_CYCLES(REP)) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_all_zero();
    pif.a1_raw        = 1'b0;
    pif.sw1_raw       = 1'b0;
    pif.sw2_raw       = 1'b0;
    pif.sw_choose_raw = 1'b0;
    pif.d_raw         = 8'h00;
  endtask

  task automatic do_reset();
    drive_all_zero();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  // Expected a1_pulse cycles for a debounced press whose level is 1 from
  // cycle lvl_rise until the edge at cycle lvl_fall
  task automatic push_pulses(input int lvl_rise, input int lvl_fall);
    pulse_q.push_back(lvl_rise + 1);
`ifdef PANEL_AUTOREPEAT_EN
    for (int p = lvl_rise + 1 + REP; p <= lvl_fall; p += REP) pulse_q.push_back(p);
`endif
  endtask

  // Scoreboard: every strobe must match the head of its queue
  always @(negedge clk) begin
    if (pif.a1_pulse === 1'b1) begin
      if (pulse_q.size() == 0) check("a1_pulse_extra", cyc, -1);
      else check("a1_pulse_cycle", cyc, pulse_q.pop_front());
    end
    if (pif.state_chg === 1'b1) begin
      if (chg_q.size() == 0) begin
        check("state_chg_extra", cyc, -1);
      end else begin
        chg_t ev;
        ev = chg_q.pop_front();
        check("state_chg_cycle", cyc, ev.at);
        check("state_chg_value", pif.cpustate, ev.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;

    // 1: reset and idle inputs
    drive_all_zero();
    rst = 1'b1;
    tick(3);
    check("rst_a1_level", pif.a1_level, 0);
    check("rst_a1_pulse", pif.a1_pulse, 0);
    check("rst_sw1", pif.sw1, 0);
    check("rst_sw2", pif.sw2, 0);
    check("rst_sw_choose", pif.sw_choose, 0);
    check("rst_d", pif.d, 0);
    check("rst_cpustate", pif.cpustate, 0);
    check("rst_state_chg", pif.state_chg, 0);
    rst = 1'b0;
    tick(20);
    check("idle_cpustate", pif.cpustate, 0);
    check("idle_d", pif.d, 0);

    // sw_choose alone follows with the standard latency and leaves the mode alone
    pif.sw_choose_raw = 1'b1;
    tick(DEB + 1);
    check("choose_early", pif.sw_choose, 0);
    tick(1);
    check("choose_set", pif.sw_choose, 1);

    // 2: bouncing key, then a clean hold
    for (int i = 0; i < 2; i++) begin
      pif.a1_raw = 1'b1;
      tick(2);
      pif.a1_raw = 1'b0;
      tick(2);
    end
    check("bounce_level", pif.a1_level, 0);
    n = cyc;
    pif.a1_raw = 1'b1;
    push_pulses(n + DEB + 2, n + 20 + DEB + 2);
    tick(DEB + 1);
    check("a1_level_early", pif.a1_level, 0);
    tick(1);
    check("a1_level_set", pif.a1_level, 1);
    tick(14);
    pif.a1_raw = 1'b0;
    tick(12);
    check("a1_level_clear", pif.a1_level, 0);
    check("t2_pulses_left", pulse_q.size(), 0);

    // 3: data vector, short glitch, and a restart on a partial change
    n = cyc;
    pif.d_raw = 8'h5A;
    tick(DEB + 1);
    check("d_early", pif.d, 8'h00);
    tick(1);
    check("d_set", pif.d, 8'h5A);
    pif.d_raw = 8'hFF;
    tick(3);
    pif.d_raw = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("d_glitch_hold", pif.d, 8'h5A);
    end
    pif.d_raw = 8'h5B;
    tick(2);
    pif.d_raw = 8'h7B;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("d_restart", pif.d, (k >= DEB + 2) ? 8'h7B : 8'h5A);
    end

    // 4: mode change while the key is held applies after release
    n = cyc;
    pif.a1_raw = 1'b1;
    push_pulses(n + DEB + 2, n + 18 + DEB + 2);
    tick(DEB + 2);
    check("t4_level", pif.a1_level, 1);
    pif.sw1_raw = 1'b1;
    pif.sw2_raw = 1'b1;
    tick(12);
    check("t4_sw1", pif.sw1, 1);
    check("t4_sw2", pif.sw2, 1);
    check("t4_frozen", pif.cpustate, 0);
    pif.a1_raw = 1'b0;
    r = cyc;
    chg_q.push_back('{at: r + DEB + 3, st: 2'b11});
    tick(DEB + 2);
    check("t4_level_fall", pif.a1_level, 0);
    check("t4_still_idle", pif.cpustate, 0);
    tick(1);
    check("t4_run", pif.cpustate, 3);
    tick(5);
    check("t4_pulses_left", pulse_q.size(), 0);
    check("t4_chg_left", chg_q.size(), 0);

    // 5: long hold (auto-repeat when enabled)
    n = cyc;
    pif.a1_raw = 1'b1;
    push_pulses(n + DEB + 2, n + 36 + DEB + 2);
    tick(36);
    pif.a1_raw = 1'b0;
    tick(12);
    check("t5_pulses_left", pulse_q.size(), 0);
    check("t5_cpustate", pif.cpustate, 3);

    // 6: reset mid-count, then re-debounce of an already-high switch
    do_reset();
    check("t6_reset_cpustate", pif.cpustate, 0);
    pif.sw1_raw = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);
    check("t6_sw1_in_rst", pif.sw1, 0);
    rst = 1'b0;
    r = cyc;
    chg_q.push_back('{at: r + DEB + 3, st: 2'b10});
    tick(DEB + 1);
    check("t6_sw1_early", pif.sw1, 0);
    tick(1);
    check("t6_sw1_set", pif.sw1, 1);
    check("t6_cpustate_pre", pif.cpustate, 0);
    tick(1);
    check("t6_check_mode", pif.cpustate, 2);
    tick(3);
    check("t6_chg_left", chg_q.size(), 0);

    // 7: key held through reset gives one fresh press pulse
    do_reset();
    n = cyc;
    pif.a1_raw = 1'b1;
    push_pulses(n + DEB + 2, n + 10);
    tick(10);
    rst = 1'b1;
    tick(3);
    check("t7_level_rst", pif.a1_level, 0);
    check("t7_pulses_pre", pulse_q.size(), 0);
    r = cyc;
    push_pulses(r + DEB + 2, r + 16 + DEB + 2);
    rst = 1'b0;
    tick(DEB + 2);
    check("t7_level", pif.a1_level, 1);
    tick(10);
    pif.a1_raw = 1'b0;
    tick(12);
    check("t7_pulses_left", pulse_q.size(), 0);
    check("final_chg_left", chg_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/panel_input.md
# panel_input

Front-panel conditioning stage feeding the CPU top level. Synchronises and debounces the raw board switches (SW1, SW2, SW_choose, D[7:0]) and the A1 push key, emits a single-cycle A1 strobe, and produces the registered 2-bit `cpustate` consumed by the cpu and ram. It replaces the direct wiring of raw switches into the CPU state decode and memory loader. The mode is frozen while the key is held.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a debounced output updates; legal range ≥1.
- `CNT_W`, default 24: debounce/repeat counter width; must hold `DEBOUNCE_CYCLES` and `REPEAT_CYCLES`.
- `REPEAT_CYCLES`, default 8: auto-repeat period, used only under `PANEL_AUTOREPEAT_EN`.
- `clk` in 1: single clock, the undivided board clock.
- `rst` in 1: synchronous, active-high reset.
- `a1_raw` in 1: raw A1 key, active-high.
- `sw1_raw`, `sw2_raw`, `sw_choose_raw` in 1 each: raw switches.
- `d_raw` in 8: raw data switches.
- `a1_level` out 1: debounced A1 level.
- `a1_pulse` out 1: one-cycle strobe on each debounced A1 press.
- `sw1`, `sw2`, `sw_choose` out 1 each: debounced switches.
- `d` out 8: debounced data switches.
- `cpustate` out 2: registered CPU mode.
- `state_chg` out 1: one-cycle strobe in the cycle `cpustate` takes a new value.

## Operation
- Each input has a 2-flop synchroniser followed by a debouncer.
- Debouncer holds `stable`. While the synchronised value ≠ `stable`, the counter increments. When the counter reaches `DEBOUNCE_CYCLES-1` and the values still differ, `stable` takes the synchronised value and the counter clears.
- The counter clears in any cycle where synchronised == `stable`. A glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never propagates.
- `d` is debounced as one 8-bit vector with one counter. Any change in any bit restarts the count. `d` updates atomically and never shows a mix of old and new bits.
- `a1_pulse` = rising edge of `a1_level`, registered.
- Mode decode: target = {sw1, sw2}. Encodings: 00 IDLE, 01 LOAD, 10 CHECK, 11 RUN.
- `cpustate` loads target only when `a1_level` = 0 and target ≠ `cpustate`. `state_chg` pulses in that same cycle.
- While `a1_level` = 1, `cpustate` holds. A switch change made during a key hold applies in the first cycle after `a1_level` falls.

## Timing
- Reset: all outputs 0, `cpustate` = IDLE, all counters and synchronisers 0.
- Latency from the first sampling edge of a held raw change to the debounced output: `DEBOUNCE_CYCLES`+2 cycles.
- `a1_pulse` rises one cycle after `a1_level` rises and is exactly one cycle wide.
- `cpustate` updates one cycle after `sw1`/`sw2` change (key released), or one cycle after `a1_level` falls (key held).
- Simultaneous key release and switch change: `cpustate` uses the switch values registered in that cycle.
- `rst` asserted mid-count: state returns to reset values on the next edge and no pulse is emitted. After `rst` deasserts, inputs that are already high re-debounce from 0. A key held through reset produces one `a1_pulse`.

## Configuration
- `PANEL_AUTOREPEAT_EN` defined: while `a1_level` = 1, a repeat counter runs. `a1_pulse` fires again every `REPEAT_CYCLES` cycles after the initial press pulse. The repeat counter clears when `a1_level` falls.
- `PANEL_AUTOREPEAT_EN` undefined: exactly one pulse per press. The repeat logic and the `REPEAT_CYCLES` counter are absent.

## Structure
- Shared package `cpu_pkg` holds:
  - `cpustate` encodings `CPU_IDLE`, `CPU_LOAD`, `CPU_CHECK`, `CPU_RUN`, which the cpu, ram and light_show also use;
  - the default `DEBOUNCE_CYCLES` for synthesis and simulation.
- One sub-module, `debounce`: parameters `WIDTH` and `DEBOUNCE_CYCLES`; contains synchroniser, counter and `stable` register.
- Instances: `debounce` ×4 at `WIDTH`=1 (A1, SW1, SW2, SW_choose) and ×1 at `WIDTH`=8 (D).
- Edge detection, mode register and auto-repeat live in `panel_input`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=8.
1. Reset, then all raw inputs held 0 → all outputs 0, `cpustate`=00, no strobes for 20 cycles.
2. `a1_raw` bounces 1/0/1/0 with 2 cycles per phase, then is held 1 for 20 cycles → exactly one `a1_pulse`, 7 cycles after the final rise is first sampled (`a1_level` at 6).
3. `d_raw`=0x5A held → `d`=0x5A after 6 cycles. Then `d_raw`=0xFF for 3 cycles, back to 0x5A → `d` stays 0x5A.
4. Hold A1; set `sw1`=1, `sw2`=1 → `cpustate` stays 00. Release A1 → `cpustate`=11 one cycle after `a1_level` falls, with one `state_chg` pulse.
5. With `PANEL_AUTOREPEAT_EN`, hold A1 for 30 cycles after `a1_level` rises → pulses at +1, +9, +17, +25. Without the macro → a single pulse.
6. Raise `sw1_raw`, assert `rst` 2 cycles later → `sw1` stays 0 and the counter clears. Deassert `rst` with `sw1_raw` still 1 → `sw1`=1 after 6 cycles and `cpustate`=10 one cycle later.
